// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cpu / external-master memory port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CPU,
    S_EXT
  } state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_EXT = 1'b1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between the cpu (stalled via clock-enable)
// and one external master, with burst limit and guaranteed cpu slot.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned CPU_SLOT  = 4
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic [15:0] I_CPU_ADDR,
  input  logic [7:0]  I_CPU_DATA,
  input  logic        I_CPU_WREN,
  output logic        O_CPU_CE,
  input  logic        I_EXT_REQ,
  input  logic        I_EXT_LOCK,
  input  logic [15:0] I_EXT_ADDR,
  input  logic [7:0]  I_EXT_DATA,
  input  logic        I_EXT_WREN,
  output logic        O_EXT_GNT,
  output logic        O_EXT_RVALID,
  output logic [7:0]  O_EXT_RDATA,
  output logic [15:0] O_MEM_ADDR,
  output logic [7:0]  O_MEM_DATA,
  output logic        O_MEM_WREN,
  input  logic [7:0]  I_MEM_DATA
);

  localparam logic [7:0] SLOT_MAX   = 8'(CPU_SLOT);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t     state;
  logic [7:0] burst_cnt;
  logic [7:0] slot_cnt;
  logic [7:0] slot_inc;
  logic       want;
  logic       owner;
  logic       ext_read;

  assign want     = I_EXT_REQ | I_EXT_LOCK;
  assign slot_inc = (slot_cnt >= SLOT_MAX) ? slot_cnt : slot_cnt + 8'd1;
  assign ext_read = (state == S_EXT) & I_EXT_REQ & ~I_EXT_WREN;
  assign owner    = (state == S_EXT) ? OWNER_EXT : OWNER_CPU;

  assign O_CPU_CE  = (state == S_CPU);
  assign O_EXT_GNT = (state == S_EXT);

  // Slot test uses the count including the current cycle so the cpu gets exactly
  // CPU_SLOT enabled cycles; burst test uses >= so a dropped LOCK ends an overlong burst.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= S_IDLE;
      burst_cnt    <= '0;
      slot_cnt     <= '0;
      O_EXT_RVALID <= 1'b0;
      O_EXT_RDATA  <= '0;
    end else begin
      O_EXT_RVALID <= ext_read;
      if (ext_read) O_EXT_RDATA <= I_MEM_DATA;
      case (state)
        S_IDLE: begin
          slot_cnt  <= '0;
          burst_cnt <= '0;
          state     <= want ? S_EXT : S_CPU;
        end
        S_CPU: begin
          slot_cnt <= slot_inc;
          if (want && slot_inc >= SLOT_MAX) begin
            state     <= S_EXT;
            burst_cnt <= '0;
          end
        end
        S_EXT: begin
          if (I_EXT_REQ) burst_cnt <= sat_inc(burst_cnt);
          if (!I_EXT_LOCK && (!I_EXT_REQ || burst_cnt >= BURST_LAST)) begin
            state    <= S_CPU;
            slot_cnt <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    O_MEM_ADDR = I_CPU_ADDR;
    O_MEM_DATA = I_CPU_DATA;
    O_MEM_WREN = 1'b0;
    if (owner == OWNER_EXT) begin
      O_MEM_ADDR = I_EXT_ADDR;
      O_MEM_DATA = I_EXT_DATA;
      O_MEM_WREN = I_EXT_REQ & I_EXT_WREN;
    end else if (state == S_CPU) begin
      O_MEM_WREN = I_CPU_WREN;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against an ownership/slot reference model.
module tb_mem_arbiter;

  localparam int MAX_BURST = 16;
  localparam int CPU_SLOT  = 4;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [15:0] I_CPU_ADDR = '0;
  logic [7:0]  I_CPU_DATA = '0;
  logic        I_CPU_WREN = 1'b0;
  logic        O_CPU_CE;
  logic        I_EXT_REQ = 1'b0;
  logic        I_EXT_LOCK = 1'b0;
  logic [15:0] I_EXT_ADDR = '0;
  logic [7:0]  I_EXT_DATA = '0;
  logic        I_EXT_WREN = 1'b0;
  logic        O_EXT_GNT;
  logic        O_EXT_RVALID;
  logic [7:0]  O_EXT_RDATA;
  logic [15:0] O_MEM_ADDR;
  logic [7:0]  O_MEM_DATA;
  logic        O_MEM_WREN;
  logic [7:0]  I_MEM_DATA;

  mem_arbiter #(.MAX_BURST(MAX_BURST), .CPU_SLOT(CPU_SLOT)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .I_CPU_ADDR(I_CPU_ADDR), .I_CPU_DATA(I_CPU_DATA), .I_CPU_WREN(I_CPU_WREN),
    .O_CPU_CE(O_CPU_CE),
    .I_EXT_REQ(I_EXT_REQ), .I_EXT_LOCK(I_EXT_LOCK), .I_EXT_ADDR(I_EXT_ADDR),
    .I_EXT_DATA(I_EXT_DATA), .I_EXT_WREN(I_EXT_WREN),
    .O_EXT_GNT(O_EXT_GNT), .O_EXT_RVALID(O_EXT_RVALID), .O_EXT_RDATA(O_EXT_RDATA),
    .O_MEM_ADDR(O_MEM_ADDR), .O_MEM_DATA(O_MEM_DATA), .O_MEM_WREN(O_MEM_WREN),
    .I_MEM_DATA(I_MEM_DATA)
  );

  always #5 CLOCK = ~CLOCK;

  // Memory model: combinational read, write on posedge.
  logic [7:0] mem [0:65535];
  int wr2000_cnt = 0;
  int wr2000_gnt = 0;
  assign I_MEM_DATA = mem[O_MEM_ADDR];
  always @(posedge CLOCK) begin
    if (O_MEM_WREN) begin
      mem[O_MEM_ADDR] <= O_MEM_DATA;
      if (O_MEM_ADDR == 16'h2000) begin
        wr2000_cnt++;
        if (O_EXT_GNT) wr2000_gnt++;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, cpu cycles since ext released, accesses this grant.
  bit         m_idle, m_ext, m_rvalid;
  int         m_cpu_cycles, m_acc;
  logic [7:0] m_rdata;

  task automatic model_reset();
    m_idle = 1; m_ext = 0; m_rvalid = 0; m_rdata = 8'h00;
    m_cpu_cycles = 0; m_acc = 0;
  endtask

  task automatic model_step();
    bit want;
    want = I_EXT_REQ | I_EXT_LOCK;
    m_rvalid = m_ext && I_EXT_REQ && !I_EXT_WREN;
    if (m_rvalid) m_rdata = mem[I_EXT_ADDR];
    if (m_idle) begin
      m_idle = 0; m_ext = want; m_cpu_cycles = 0; m_acc = 0;
    end else if (!m_ext) begin
      m_cpu_cycles++;
      if (want && m_cpu_cycles >= CPU_SLOT) begin m_ext = 1; m_acc = 0; end
    end else begin
      if (I_EXT_REQ) m_acc++;
      if (!I_EXT_LOCK && (!I_EXT_REQ || m_acc >= MAX_BURST)) begin
        m_ext = 0; m_cpu_cycles = 0;
      end
    end
  endtask

  // Stimulus agents
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        cpu_wren = 1'b0;
  bit          cpu_hold = 0;
  bit          cpu_rand_wr = 1;
  int          ext_left = 0;
  bit          ext_hold = 0;
  bit          ext_lock = 0;
  bit          ext_wr = 0;
  logic [15:0] ext_addr = 16'h1000;
  logic [7:0]  rq [$];
  bit          prev_gnt = 0;
  int          acc_run = 0, ce_run = 0, last_burst = 0, last_slot = 0, ce_total = 0;

  task automatic cycle();
    bit req;
    if (!cpu_hold) begin
      cpu_addr = 16'h4000 | 16'($urandom_range(0, 4095));
      cpu_data = 8'($urandom);
      cpu_wren = cpu_rand_wr && ($urandom_range(0, 3) == 0);
    end
    req = ext_hold || (ext_left > 0);
    I_CPU_ADDR = cpu_addr; I_CPU_DATA = cpu_data; I_CPU_WREN = cpu_wren;
    I_EXT_REQ = req; I_EXT_LOCK = ext_lock; I_EXT_ADDR = ext_addr;
    I_EXT_DATA = 8'($urandom); I_EXT_WREN = ext_wr;
    #1;
    check("ce", O_CPU_CE, !m_idle && !m_ext);
    check("gnt", O_EXT_GNT, m_ext);
    check("mem_addr", O_MEM_ADDR, m_ext ? I_EXT_ADDR : I_CPU_ADDR);
    check("mem_data", O_MEM_DATA, m_ext ? I_EXT_DATA : I_CPU_DATA);
    check("mem_wren", O_MEM_WREN, m_idle ? 1'b0 : (m_ext ? (req && ext_wr) : cpu_wren));
    check("rvalid", O_EXT_RVALID, m_rvalid);
    check("rdata", O_EXT_RDATA, m_rdata);
    if (O_EXT_RVALID) rq.push_back(O_EXT_RDATA);
    cpu_hold = cpu_wren && !O_CPU_CE;
    if (O_EXT_GNT) begin
      if (!prev_gnt) begin last_slot = ce_run; ce_run = 0; end
      if (req) begin
        acc_run++;
        if (ext_left > 0) ext_left--;
        ext_addr = 16'h1000 | ((ext_addr + 16'd1) & 16'h0FFF);
      end
    end else begin
      if (prev_gnt) begin last_burst = acc_run; acc_run = 0; end
      if (O_CPU_CE) ce_run++;
    end
    if (O_CPU_CE) ce_total++;
    prev_gnt = O_EXT_GNT;
    model_step();
    @(posedge CLOCK);
    @(negedge CLOCK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_gnt(input string tag);
    int budget;
    budget = 100;
    while (!O_EXT_GNT && budget > 0) begin cycle(); budget--; end
    check(tag, O_EXT_GNT, 1'b1);
  endtask

  initial begin
    int snap, budget;
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a ^ (a >> 8));
    model_reset();
    repeat (3) @(negedge CLOCK);
    RESET_N = 1'b1;

    // 1: reset release with no request
    #1;
    check("t1_ce_idle", O_CPU_CE, 1'b0);
    check("t1_wren_idle", O_MEM_WREN, 1'b0);
    #1;
    run(8);
    check("t1_ce_run", O_CPU_CE, 1'b1);

    // 2: read burst of three
    mem[16'h1000] = 8'hAA; mem[16'h1001] = 8'hBB; mem[16'h1002] = 8'hCC;
    rq.delete();
    ext_addr = 16'h1000; ext_wr = 0; ext_left = 3;
    run(12);
    check("t2_rcount", rq.size(), 3);
    if (rq.size() == 3) begin
      check("t2_rd0", rq[0], 8'hAA);
      check("t2_rd1", rq[1], 8'hBB);
      check("t2_rd2", rq[2], 8'hCC);
    end
    check("t2_ce_back", O_CPU_CE, 1'b1);

    // 3: continuous request, burst limit and cpu slot
    ext_hold = 1; ext_wr = 0;
    run(70);
    check("t3_burst_len", last_burst, MAX_BURST);
    check("t3_slot_len", last_slot, CPU_SLOT);
    ext_hold = 0;
    run(6);

    // 4: cpu write frozen by an ext grant
    wr2000_cnt = 0; wr2000_gnt = 0;
    ext_hold = 1; ext_wr = 1; ext_addr = 16'h1800;
    wait_gnt("t4_gnt");
    cpu_addr = 16'h2000; cpu_data = 8'h5A; cpu_wren = 1; cpu_hold = 1;
    run(5);
    check("t4_no_early_write", wr2000_cnt, 0);
    ext_hold = 0;
    run(30);
    check("t4_mem", mem[16'h2000], 8'h5A);
    check("t4_write_once", wr2000_cnt, 1);
    check("t4_write_in_gnt", wr2000_gnt, 0);

    // 5: locked grant beyond the burst limit
    ext_hold = 1; ext_lock = 1; ext_wr = 0;
    wait_gnt("t5_gnt");
    snap = ce_total;
    run(300);
    check("t5_no_cpu", ce_total - snap, 0);
    check("t5_still_gnt", O_EXT_GNT, 1'b1);
    ext_lock = 0;
    cycle();
    check("t5_release", O_EXT_GNT, 1'b0);
    ext_hold = 0;
    run(6);

    // Random traffic
    for (int k = 0; k < 12; k++) begin
      ext_left = $urandom_range(1, 24);
      ext_wr = $urandom_range(0, 1) == 1;
      ext_lock = $urandom_range(0, 5) == 0;
      run($urandom_range(10, 30));
      ext_lock = 0;
      run(4);
    end
    ext_left = 0;
    run(6);

    // 6: async reset during an ext write burst
    ext_left = 20; ext_wr = 1; ext_addr = 16'h1100;
    budget = 100;
    while (!(O_EXT_GNT && O_MEM_WREN) && budget > 0) begin cycle(); budget--; end
    check("t6_pre_write", O_MEM_WREN, 1'b1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("t6_wren_drop", O_MEM_WREN, 1'b0);
    check("t6_gnt_drop", O_EXT_GNT, 1'b0);
    check("t6_ce_drop", O_CPU_CE, 1'b0);
    check("t6_rvalid_drop", O_EXT_RVALID, 1'b0);
    model_reset();
    ext_left = 0; ext_wr = 0; ext_hold = 0; cpu_hold = 0; prev_gnt = 0;
    @(posedge CLOCK);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    #1;
    check("t6_ce_idle", O_CPU_CE, 1'b0);
    check("t6_rdata_reset", O_EXT_RDATA, 8'h00);
    #1;
    run(8);
    check("t6_ce_run", O_CPU_CE, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
